// File: rtl/uart_rx_ctrl_if.sv
// Parallel-side handshake of the UART receiver: byte/valid/ack plus status pulses.
// master = receiver (produces bytes), slave = consumer (acknowledges them).
interface uart_rx_ctrl_if;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       recv_ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output recv_data, recv_valid, busy, frame_err, overrun,
    input  recv_ack
  );

  modport slave (
    input  recv_data, recv_valid, busy, frame_err, overrun,
    output recv_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronises UART_RX, samples each bit at its centre and
// delivers bytes over a valid/ack handshake with framing and overrun reporting.
module uart_rx_ctrl #(
  parameter logic [13:0] TIMER_MAX = 14'd10416,
  parameter logic [13:0] HALF_MAX  = 14'd5208
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           UART_RX,
  uart_rx_ctrl_if.master rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s, rx_d;
  logic [13:0] timer, timer_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        deliver, stop_bad;

  logic [7:0]  recv_data_q;
  logic        recv_valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  // Idle-high reset values keep a low line at reset release from looking like an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the pre-edge value of the one before it.
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    state_nxt   = state;
    timer_nxt   = timer + 14'd1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    deliver     = 1'b0;
    stop_bad    = 1'b0;

    unique case (state)
      IDLE: begin
        timer_nxt = '0;
        if (rx_d && !rx_s) state_nxt = START;
      end
      START: begin
        if (timer == HALF_MAX) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == TIMER_MAX) begin
          timer_nxt   = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == TIMER_MAX) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          deliver   = rx_s;
          stop_bad  = !rx_s;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // A delivery always wins over an ack in the same cycle; overrun only if the old byte was unacked.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      recv_data_q  <= '0;
      recv_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= deliver && recv_valid_q && !rx.recv_ack;
      if (deliver) begin
        recv_data_q  <= shift;
        recv_valid_q <= 1'b1;
      end else if (recv_valid_q && rx.recv_ack) begin
        recv_valid_q <= 1'b0;
      end
    end
  end

  assign rx.recv_data  = recv_data_q;
  assign rx.recv_valid = recv_valid_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.overrun    = overrun_q;
  assign rx.busy       = (state != IDLE);

endmodule
